// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU stage controller.
// Holds the state encoding, opcode and ALU codes, and the datapath widths.
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALTED    = 3'd6
    } state_e;

    // Opcode lives in IR[7:5]; 3'b110 and 3'b111 are illegal.
    localparam logic [2:0] OP_LW   = 3'b000;
    localparam logic [2:0] OP_SW   = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ADDI = 2'b10;

    typedef enum logic [1:0] {
        CLS_LOAD  = 2'd0,
        CLS_STORE = 2'd1,
        CLS_JUMP  = 2'd2,
        CLS_ALU   = 2'd3
    } op_class_e;

endpackage

// File: rtl/cpu_decoder.sv
// Instruction decoder: classifies the IR, flags illegal opcodes,
// selects the ALU operation and forms the jump target.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] i_ir,
    output op_class_e          o_cls,
    output logic [1:0]         o_alu_op,
    output logic               o_illegal,
    output logic [ADDR_W-1:0]  o_jump_target
);

    assign o_jump_target = {3'b000, i_ir[4:0]};

    always_comb begin
        o_cls     = CLS_ALU;
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_ir[7:5])
            OP_LW:   o_cls = CLS_LOAD;
            OP_SW:   o_cls = CLS_STORE;
            OP_J:    o_cls = CLS_JUMP;
            OP_ADD:  o_alu_op = ALU_ADD;
            OP_ADDI: o_alu_op = ALU_ADDI;
            OP_SUB:  o_alu_op = ALU_SUB;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_stage_controller.sv
// Multi-cycle CPU control FSM: fetch handshake with timeout, decode,
// execute, memory and writeback sequencing, PC and retired-instruction count.
module cpu_stage_controller
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC      = 8'h00,
    parameter int                FETCH_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    output logic               fetch_req,
    output logic [ADDR_W-1:0]  program_counter,
    input  logic               fetch_ack,
    input  logic [INSTR_W-1:0] instruction,
    output logic [2:0]         stage,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               busy,
    output logic               fault,
    output logic [15:0]        instr_count
);

    localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    state_e              r_state;
    state_e              w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [15:0]         r_count;
    logic                r_fault;
    logic [WAIT_W-1:0]   r_wait;

    op_class_e           w_cls;
    logic [1:0]          w_alu_op;
    logic                w_illegal;
    logic [ADDR_W-1:0]   w_jump_target;
    logic                w_timeout;

    cpu_decoder u_decoder (
        .i_ir          (r_ir),
        .o_cls         (w_cls),
        .o_alu_op      (w_alu_op),
        .o_illegal     (w_illegal),
        .o_jump_target (w_jump_target)
    );

    // r_wait counts completed FETCH cycles, so the last allowed cycle is FETCH_TIMEOUT-1.
    assign w_timeout = (r_wait == WAIT_W'(FETCH_TIMEOUT - 1));

    assign stage           = r_state;
    assign program_counter = r_pc;
    assign fault           = r_fault;
    assign instr_count     = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_count <= '0;
            r_fault <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= (r_state == ST_FETCH) ? r_wait + WAIT_W'(1) : '0;
            if (r_state == ST_FETCH && fetch_ack)
                r_ir <= instruction;
            if ((r_state == ST_FETCH && !fetch_ack && w_timeout) ||
                (r_state == ST_DECODE && w_illegal))
                r_fault <= 1'b1;
            if (r_state == ST_EXECUTE && w_cls == CLS_JUMP)
                r_pc <= w_jump_target;
            // Retirement: jumps already loaded their target in EXECUTE.
            if (r_state == ST_WRITEBACK) begin
                if (w_cls != CLS_JUMP)
                    r_pc <= r_pc + ADDR_W'(1);
                if (r_count != 16'hFFFF)
                    r_count <= r_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        fetch_req    = 1'b0;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack)      w_next_state = ST_DECODE;
                else if (w_timeout) w_next_state = ST_HALTED;
            end
            ST_DECODE:
                w_next_state = w_illegal ? ST_HALTED : ST_EXECUTE;
            ST_EXECUTE: begin
                alu_op = w_alu_op;
                if (w_cls == CLS_LOAD || w_cls == CLS_STORE) w_next_state = ST_MEMORY;
                else                                          w_next_state = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                mem_read     = (w_cls == CLS_LOAD);
                mem_write    = (w_cls == CLS_STORE);
                w_next_state = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                reg_write    = (w_cls == CLS_LOAD || w_cls == CLS_ALU);
                w_next_state = halt_req ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: begin
                busy = 1'b0;
                if (start) w_next_state = ST_FETCH;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_stage_controller.sv
// Randomized bench for cpu_stage_controller: per-instruction expected stage
// and PC trace built from the instruction semantics, compared cycle by cycle.
module tb_cpu_stage_controller;

    localparam logic [7:0] RESET_PC      = 8'h00;
    localparam int         FETCH_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n, start, halt_req, fetch_ack;
    logic [7:0]  instruction;
    logic        fetch_req, reg_write, mem_read, mem_write, busy, fault;
    logic [7:0]  program_counter;
    logic [2:0]  stage;
    logic [1:0]  alu_op;
    logic [15:0] instr_count;

    cpu_stage_controller #(
        .RESET_PC      (RESET_PC),
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .halt_req        (halt_req),
        .fetch_req       (fetch_req),
        .program_counter (program_counter),
        .fetch_ack       (fetch_ack),
        .instruction     (instruction),
        .stage           (stage),
        .alu_op          (alu_op),
        .reg_write       (reg_write),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .busy            (busy),
        .fault           (fault),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_count;
    logic        m_fault;
    // Each entry is {stage, program_counter} expected for one cycle.
    logic [10:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input logic [2:0] st, input logic [7:0] pc, input logic [2:0] op);
        check_eq("stage", stage, st);
        check_eq("pc", program_counter, pc);
        check_eq("fetch_req", fetch_req, st == 3'd1);
        check_eq("busy", busy, st != 3'd0 && st != 3'd6);
        check_eq("reg_write", reg_write,
                 st == 3'd5 && (op == 3'd0 || op == 3'd3 || op == 3'd4 || op == 3'd5));
        check_eq("mem_read", mem_read, st == 3'd4 && op == 3'd0);
        check_eq("mem_write", mem_write, st == 3'd4 && op == 3'd1);
        check_eq("one_strobe", (int'(reg_write) + int'(mem_read) + int'(mem_write)) <= 1, 1);
        if (st == 3'd3 && op != 3'd2)
            check_eq("alu_op", alu_op, (op == 3'd5) ? 2'b01 : (op == 3'd4) ? 2'b10 : 2'b00);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_stage"}, stage, 3'd0);
        check_eq({tag, "_pc"}, program_counter, RESET_PC);
        check_eq({tag, "_count"}, instr_count, 16'd0);
        check_eq({tag, "_fault"}, fault, 1'b0);
        check_eq({tag, "_strobes"}, {fetch_req, reg_write, mem_read, mem_write, busy}, 5'b0);
        check_eq({tag, "_alu"}, alu_op, 2'b00);
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge in FETCH.
    task automatic run_instr(input logic [7:0] instr, input int delay, input bit do_halt);
        logic [2:0] op;
        logic [2:0] tail_st;
        logic [7:0] tgt;
        bit         timeout;
        int         wb_idx;
        int         halt_at;
        op      = instr[7:5];
        tgt     = {3'b000, instr[4:0]};
        timeout = (delay >= FETCH_TIMEOUT);
        wb_idx  = -1;
        exp_q.delete();
        for (int i = 0; i < (timeout ? FETCH_TIMEOUT : delay + 1); i++)
            exp_q.push_back({3'd1, m_pc});
        if (timeout) begin
            m_fault = 1'b1;
            tail_st = 3'd6;
        end else begin
            exp_q.push_back({3'd2, m_pc});
            if (op >= 3'd6) begin
                m_fault = 1'b1;
                tail_st = 3'd6;
            end else begin
                exp_q.push_back({3'd3, m_pc});
                if (op == 3'd0 || op == 3'd1) exp_q.push_back({3'd4, m_pc});
                wb_idx = exp_q.size();
                exp_q.push_back({3'd5, (op == 3'd2) ? tgt : m_pc});
                m_pc = (op == 3'd2) ? tgt : m_pc + 8'd1;
                if (m_count != 16'hFFFF) m_count++;
                tail_st = do_halt ? 3'd6 : 3'd1;
            end
        end
        halt_at = (do_halt && wb_idx >= 0) ? int'($urandom_range(wb_idx, 0)) : exp_q.size() + 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            check_cycle(exp_q[i][10:8], exp_q[i][7:0], op);
            fetch_ack   = !timeout && (i == delay);
            instruction = fetch_ack ? instr : 8'($urandom);
            halt_req    = (i >= halt_at);
        end
        @(negedge clk);
        fetch_ack = 1'b0;
        halt_req  = 1'b0;
        check_cycle(tail_st, m_pc, op);
        check_eq("instr_count", instr_count, m_count);
        check_eq("fault", fault, m_fault);
        if (tail_st == 3'd6) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq("resume_stage", stage, 3'd1);
            check_eq("resume_pc", program_counter, m_pc);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_count = '0;
        m_fault = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ins;
        int         r;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; fetch_ack = 1'b0; instruction = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        model_reset();

        halt_req = 1'b1; fetch_ack = 1'b1;
        @(negedge clk);
        check_eq("idle_ignores", stage, 3'd0);
        halt_req = 1'b0; fetch_ack = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        run_instr(8'b10000101, 2, 1'b0);   // addi
        check_eq("addi_pc", program_counter, 8'h01);
        check_eq("addi_count", instr_count, 16'd1);
        run_instr(8'b00110000, 0, 1'b0);   // sw
        run_instr(8'b00001101, 1, 1'b0);   // lw
        run_instr(8'b01000101, 0, 1'b0);   // j 5
        run_instr(8'b01000111, 3, 1'b0);   // j 7
        check_eq("jump_pc", program_counter, 8'h07);
        run_instr(8'b01100000, 0, 1'b1);   // add with halt
        run_instr(8'b11000000, 0, 1'b0);   // illegal
        check_eq("illegal_fault", fault, 1'b1);

        // Fresh run for the timeout and PC wrap cases.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_instr(8'b01100000, FETCH_TIMEOUT + 5, 1'b0);
        check_eq("timeout_fault", fault, 1'b1);
        while (m_pc != 8'hFF) begin
            ins = 8'($urandom);
            ins[7:5] = (ins[0]) ? 3'b011 : 3'b101;
            run_instr(ins, int'($urandom_range(1, 0)), 1'b0);
        end
        run_instr(8'b01100001, 0, 1'b0);
        check_eq("pc_wrap", program_counter, 8'h00);

        for (int n = 0; n < 150; n++) begin
            ins = 8'($urandom);
            r   = int'($urandom_range(99, 0));
            if (r >= 5) ins[7:5] = 3'($urandom_range(5, 0));
            r = int'($urandom_range(99, 0));
            run_instr(ins, (r < 4) ? FETCH_TIMEOUT + int'($urandom_range(3, 0))
                                   : int'($urandom_range(4, 0)),
                      ($urandom_range(9, 0) == 0));
        end

        // Reset landing in MEMORY of a store must suppress the strobe.
        fetch_ack = 1'b1; instruction = 8'b00110000;
        @(negedge clk);
        fetch_ack = 1'b0;
        check_eq("rst_mem_decode", stage, 3'd2);
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_mem_stage", stage, 3'd4);
        check_eq("rst_mem_write_before", mem_write, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("rst_in_mem");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
